// File: rtl/fetch_stage_seq.sv
// Y86-64 fetch stage: PC selection, single-outstanding instruction fetch, field split
// into the F->D register, and ownership of the F_predPC register.
`timescale 1ns/1ps
module fetch_stage_seq #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        F_stall_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [79:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        f_valid_o,
  output logic        f_busy_o,
  output logic [2:0]  f_stat_o,
  output logic [63:0] f_pc_o,
  output logic [63:0] f_valC_o,
  output logic [63:0] f_valP_o,
  output logic [3:0]  f_icode_o,
  output logic [3:0]  f_ifunc_o,
  output logic [3:0]  f_rA_o,
  output logic [3:0]  f_rB_o,
  output logic [63:0] F_predPC_o
);

  localparam logic [2:0]  STAT_AOK   = 3'd1;
  localparam logic [2:0]  STAT_HLT   = 3'd2;
  localparam logic [2:0]  STAT_ADR   = 3'd3;
  localparam logic [2:0]  STAT_INS   = 3'd4;
  localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifunc;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } dec_t;

  // The end address is formed in 65 bits so a PC near 2^64 cannot wrap past the ADR check.
  function automatic dec_t decode_f(input logic [63:0] pc, input logic [79:0] rdata,
                                    input logic err);
    dec_t        d;
    logic [3:0]  len;
    logic        has_regs;
    logic        has_valc;
    logic        ins;
    logic [64:0] end_addr;
    d.icode = rdata[7:4];
    d.ifunc = rdata[3:0];
    case (rdata[7:4])
      4'h0, 4'h1, 4'h9: begin len = 4'd1;  has_regs = 1'b0; has_valc = 1'b0; ins = 1'b0; end
      4'h2, 4'h6, 4'hA, 4'hB: begin
                        len = 4'd2;  has_regs = 1'b1; has_valc = 1'b0; ins = 1'b0; end
      4'h3, 4'h4, 4'h5: begin len = 4'd10; has_regs = 1'b1; has_valc = 1'b1; ins = 1'b0; end
      4'h7, 4'h8:       begin len = 4'd9;  has_regs = 1'b0; has_valc = 1'b1; ins = 1'b0; end
      default:          begin len = 4'd1;  has_regs = 1'b0; has_valc = 1'b0; ins = 1'b1; end
    endcase
    d.ra     = has_regs ? rdata[15:12] : 4'hF;
    d.rb     = has_regs ? rdata[11:8]  : 4'hF;
    d.valc   = has_valc ? (has_regs ? rdata[79:16] : rdata[71:8]) : 64'h0;
    d.valp   = pc + {60'h0, len};
    end_addr = {1'b0, pc} + {61'h0, len};
    if (err || (end_addr > IMEM_LIMIT)) begin
      d.stat = STAT_ADR;
    end else if (ins) begin
      d.stat = STAT_INS;
    end else if (rdata[7:4] == 4'h0) begin
      d.stat = STAT_HLT;
    end else begin
      d.stat = STAT_AOK;
    end
    return d;
  endfunction

  state_t      state_r;
  logic [63:0] fetch_pc_r;
  logic [63:0] pred_pc_r;
  logic        pending_r;
  logic [63:0] pending_pc_r;
  logic        req_r;
  logic        f_valid_r;
  logic        f_busy_r;
  logic [2:0]  f_stat_r;
  logic [63:0] f_pc_r;
  logic [63:0] f_valc_r;
  logic [63:0] f_valp_r;
  logic [3:0]  f_icode_r;
  logic [3:0]  f_ifunc_r;
  logic [3:0]  f_ra_r;
  logic [3:0]  f_rb_r;

  logic        redirect_valid_s;
  logic [63:0] redirect_pc_s;
  logic [63:0] pred_next_s;
  dec_t        dec_s;

  // Redirect source: a mispredicted jXX in M outranks a ret in W.
  always_comb begin
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 64'h0;
    if ((M_icode_i == 4'h7) && !M_cnd_i) begin
      redirect_valid_s = 1'b1;
      redirect_pc_s    = M_valA_i;
    end else if (W_icode_i == 4'h9) begin
      redirect_valid_s = 1'b1;
      redirect_pc_s    = W_valM_i;
    end else begin
      redirect_valid_s = 1'b0;
      redirect_pc_s    = 64'h0;
    end
  end

  // Jumps and calls are predicted taken; everything else falls through.
  always_comb begin
    pred_next_s = f_valp_r;
    if ((f_icode_r == 4'h7) || (f_icode_r == 4'h8)) begin
      pred_next_s = f_valc_r;
    end else begin
      pred_next_s = f_valp_r;
    end
  end

  assign dec_s = decode_f(fetch_pc_r, imem_rdata_i, imem_err_i);

  // Fetch FSM together with the F->D output register and the predicted-PC register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_IDLE;
      fetch_pc_r   <= RESET_PC;
      pred_pc_r    <= RESET_PC;
      pending_r    <= 1'b0;
      pending_pc_r <= 64'h0;
      req_r        <= 1'b0;
      f_valid_r    <= 1'b0;
      f_busy_r     <= 1'b1;
      f_stat_r     <= 3'd0;
      f_pc_r       <= 64'h0;
      f_valc_r     <= 64'h0;
      f_valp_r     <= 64'h0;
      f_icode_r    <= 4'h1;
      f_ifunc_r    <= 4'h0;
      f_ra_r       <= 4'hF;
      f_rb_r       <= 4'hF;
    end else begin
      req_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (redirect_valid_s) begin
            fetch_pc_r <= redirect_pc_s;
          end
          state_r <= ST_REQ;
          req_r   <= 1'b1;
        end
        ST_REQ: begin
          if (redirect_valid_s) begin
            pending_r    <= 1'b1;
            pending_pc_r <= redirect_pc_s;
          end
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect_valid_s) begin
              fetch_pc_r <= redirect_pc_s;
              pending_r  <= 1'b0;
              state_r    <= ST_REQ;
              req_r      <= 1'b1;
            end else if (pending_r) begin
              fetch_pc_r <= pending_pc_r;
              pending_r  <= 1'b0;
              state_r    <= ST_REQ;
              req_r      <= 1'b1;
            end else begin
              f_valid_r <= 1'b1;
              f_busy_r  <= 1'b0;
              f_stat_r  <= dec_s.stat;
              f_pc_r    <= fetch_pc_r;
              f_valc_r  <= dec_s.valc;
              f_valp_r  <= dec_s.valp;
              f_icode_r <= dec_s.icode;
              f_ifunc_r <= dec_s.ifunc;
              f_ra_r    <= dec_s.ra;
              f_rb_r    <= dec_s.rb;
              state_r   <= ST_VALID;
            end
          end else if (redirect_valid_s) begin
            pending_r    <= 1'b1;
            pending_pc_r <= redirect_pc_s;
          end
        end
        ST_VALID: begin
          if (redirect_valid_s) begin
            fetch_pc_r <= redirect_pc_s;
            f_valid_r  <= 1'b0;
            f_busy_r   <= 1'b1;
            state_r    <= ST_REQ;
            req_r      <= 1'b1;
          end else if (!F_stall_i) begin
            pred_pc_r <= pred_next_s;
            f_valid_r <= 1'b0;
            f_busy_r  <= 1'b1;
            if (f_stat_r != STAT_AOK) begin
              state_r <= ST_HALT;
            end else begin
              fetch_pc_r <= pred_next_s;
              state_r    <= ST_REQ;
              req_r      <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (redirect_valid_s) begin
            fetch_pc_r <= redirect_pc_s;
            state_r    <= ST_REQ;
            req_r      <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = fetch_pc_r;
  assign f_valid_o   = f_valid_r;
  assign f_busy_o    = f_busy_r;
  assign f_stat_o    = f_stat_r;
  assign f_pc_o      = f_pc_r;
  assign f_valC_o    = f_valc_r;
  assign f_valP_o    = f_valp_r;
  assign f_icode_o   = f_icode_r;
  assign f_ifunc_o   = f_ifunc_r;
  assign f_rA_o      = f_ra_r;
  assign f_rB_o      = f_rb_r;
  assign F_predPC_o  = pred_pc_r;

endmodule

// File: tb/tb_fetch_stage_seq.sv
// Directed bench for fetch_stage_seq: an imem responder driven step by step, with
// expected fetch results queued when a response is driven and popped on f_valid.
`timescale 1ns/1ps
module tb_fetch_stage_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        F_stall_i;
  logic [3:0]  M_icode_i;
  logic        M_cnd_i;
  logic [63:0] M_valA_i;
  logic [3:0]  W_icode_i;
  logic [63:0] W_valM_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [79:0] imem_rdata_i;
  logic        imem_err_i;
  logic        f_valid_o;
  logic        f_busy_o;
  logic [2:0]  f_stat_o;
  logic [63:0] f_pc_o;
  logic [63:0] f_valC_o;
  logic [63:0] f_valP_o;
  logic [3:0]  f_icode_o;
  logic [3:0]  f_ifunc_o;
  logic [3:0]  f_rA_o;
  logic [3:0]  f_rB_o;
  logic [63:0] F_predPC_o;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifunc;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage_seq #(.RESET_PC(64'h0), .IMEM_SIZE(1024)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .F_stall_i(F_stall_i),
    .M_icode_i(M_icode_i), .M_cnd_i(M_cnd_i), .M_valA_i(M_valA_i),
    .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .f_valid_o(f_valid_o), .f_busy_o(f_busy_o), .f_stat_o(f_stat_o),
    .f_pc_o(f_pc_o), .f_valC_o(f_valC_o), .f_valP_o(f_valP_o),
    .f_icode_o(f_icode_o), .f_ifunc_o(f_ifunc_o), .f_rA_o(f_rA_o), .f_rB_o(f_rB_o),
    .F_predPC_o(F_predPC_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [3:0] icode,
                              input logic [3:0] ifunc, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] valc,
                              input logic [63:0] valp, input logic [2:0] stat);
    exp_t e;
    e.pc = pc; e.icode = icode; e.ifunc = ifunc; e.ra = ra; e.rb = rb;
    e.valc = valc; e.valp = valp; e.stat = stat;
    return e;
  endfunction

  task automatic check_bubble(input string tag);
    chk({tag, ".valid"}, {63'h0, f_valid_o}, 64'h0);
    chk({tag, ".busy"},  {63'h0, f_busy_o},  64'h1);
    chk({tag, ".stat"},  {61'h0, f_stat_o},  64'h0);
    chk({tag, ".pc"},    f_pc_o,             64'h0);
    chk({tag, ".valc"},  f_valC_o,           64'h0);
    chk({tag, ".valp"},  f_valP_o,           64'h0);
    chk({tag, ".icode"}, {60'h0, f_icode_o}, 64'h1);
    chk({tag, ".ifunc"}, {60'h0, f_ifunc_o}, 64'h0);
    chk({tag, ".ra"},    {60'h0, f_rA_o},    64'hF);
    chk({tag, ".rb"},    {60'h0, f_rB_o},    64'hF);
    chk({tag, ".req"},   {63'h0, imem_req_o}, 64'h0);
    chk({tag, ".pred"},  F_predPC_o,         64'h0);
  endtask

  task automatic wait_req(input logic [63:0] addr, input string tag);
    int n = 0;
    while ((imem_req_o !== 1'b1) && (n < 30)) begin
      step();
      n++;
    end
    chk({tag, ".req"},  {63'h0, imem_req_o}, 64'h1);
    chk({tag, ".addr"}, imem_addr_o, addr);
  endtask

  task automatic respond(input int lat, input logic [79:0] data, input logic err);
    repeat (lat) step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    imem_err_i    = err;
    step();
    imem_rvalid_i = 1'b0;
    imem_err_i    = 1'b0;
    imem_rdata_i  = 80'h0;
  endtask

  task automatic check_fetch(input string tag);
    exp_t e;
    int   n = 0;
    while ((f_valid_o !== 1'b1) && (n < 10)) begin
      step();
      n++;
    end
    chk({tag, ".valid"}, {63'h0, f_valid_o}, 64'h1);
    chk({tag, ".busy"},  {63'h0, f_busy_o},  64'h0);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 64'h0, 64'h1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".pc"},    f_pc_o,             e.pc);
      chk({tag, ".icode"}, {60'h0, f_icode_o}, {60'h0, e.icode});
      chk({tag, ".ifunc"}, {60'h0, f_ifunc_o}, {60'h0, e.ifunc});
      chk({tag, ".ra"},    {60'h0, f_rA_o},    {60'h0, e.ra});
      chk({tag, ".rb"},    {60'h0, f_rB_o},    {60'h0, e.rb});
      chk({tag, ".valc"},  f_valC_o,           e.valc);
      chk({tag, ".valp"},  f_valP_o,           e.valp);
      chk({tag, ".stat"},  {61'h0, f_stat_o},  {61'h0, e.stat});
    end
  endtask

  initial begin
    rst_n_i = 1'b0; F_stall_i = 1'b0;
    M_icode_i = 4'h0; M_cnd_i = 1'b0; M_valA_i = 64'h0;
    W_icode_i = 4'h0; W_valM_i = 64'h0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 80'h0; imem_err_i = 1'b0;
    repeat (2) step();
    check_bubble("reset");
    rst_n_i = 1'b1;

    // nop at 0, one-cycle latency, then acceptance updates the predicted PC
    wait_req(64'h0, "req_nop");
    exp_q.push_back(mk(64'h0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd1));
    respond(1, {72'h0, 8'h10}, 1'b0);
    check_fetch("nop");
    step();
    chk("pred_nop", F_predPC_o, 64'h1);
    wait_req(64'h1, "req_jxx");

    // jXX 0x40 predicted taken, then a mispredict during WAIT drops the response
    exp_q.push_back(mk(64'h1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'hA, 3'd1));
    respond(1, {8'h00, 64'h40, 8'h70}, 1'b0);
    check_fetch("jxx");
    step();
    chk("pred_jxx", F_predPC_o, 64'h40);
    wait_req(64'h40, "req_target");
    step();
    M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h9;
    step();
    M_icode_i = 4'h0; M_valA_i = 64'h0;
    respond(1, {72'h0, 8'h10}, 1'b0);
    chk("dropped.valid", {63'h0, f_valid_o}, 64'h0);
    wait_req(64'h9, "req_recover");

    // rrmovq held by F_stall for three cycles, then exactly one request
    exp_q.push_back(mk(64'h9, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'hB, 3'd1));
    respond(2, {64'h0, 8'h12, 8'h20}, 1'b0);
    check_fetch("rrmov");
    F_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.valid", {63'h0, f_valid_o}, 64'h1);
      chk("stall.pc",    f_pc_o, 64'h9);
      chk("stall.req",   {63'h0, imem_req_o}, 64'h0);
    end
    F_stall_i = 1'b0;
    step();
    chk("release.req",  {63'h0, imem_req_o}, 64'h1);
    chk("release.addr", imem_addr_o, 64'hB);
    chk("release.pred", F_predPC_o, 64'hB);
    step();
    chk("single.req", {63'h0, imem_req_o}, 64'h0);

    // halt: no further requests until a ret in W redirects
    exp_q.push_back(mk(64'hB, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hC, 3'd2));
    respond(1, {72'h0, 8'h00}, 1'b0);
    check_fetch("halt");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halted.req",   {63'h0, imem_req_o}, 64'h0);
      chk("halted.valid", {63'h0, f_valid_o}, 64'h0);
    end
    W_icode_i = 4'h9; W_valM_i = 64'h20;
    step();
    W_icode_i = 4'h0; W_valM_i = 64'h0;
    wait_req(64'h20, "req_ret");

    // invalid icode, then ret redirect out of VALID to the last imem byte
    exp_q.push_back(mk(64'h20, 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 3'd4));
    respond(1, {72'h0, 8'hF0}, 1'b0);
    check_fetch("ins");
    W_icode_i = 4'h9; W_valM_i = 64'h3FF;
    step();
    W_icode_i = 4'h0; W_valM_i = 64'h0;
    wait_req(64'h3FF, "req_edge");

    // irmovq crossing the end of imem gives ADR
    exp_q.push_back(mk(64'h3FF, 4'h3, 4'h0, 4'hF, 4'h5, 64'h0123456789ABCDEF, 64'h409, 3'd3));
    respond(1, {64'h0123456789ABCDEF, 8'hF5, 8'h30}, 1'b0);
    check_fetch("adr");
    step();
    chk("adr_halt.valid", {63'h0, f_valid_o}, 64'h0);
    chk("adr_halt.req",   {63'h0, imem_req_o}, 64'h0);

    // redirect out of HALT, then reset while the request is outstanding
    M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h100;
    step();
    M_icode_i = 4'h0; M_valA_i = 64'h0;
    wait_req(64'h100, "req_mid");
    step();
    rst_n_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = {72'h0, 8'h10};
    #1;
    check_bubble("rst_wait");
    step();
    imem_rvalid_i = 1'b0; imem_rdata_i = 80'h0;
    rst_n_i = 1'b1;
    chk("rst_wait.drop", {63'h0, f_valid_o}, 64'h0);
    wait_req(64'h0, "req_after_rst");

    // irmovq at 0 with three-cycle latency; redirect beats a stall
    exp_q.push_back(mk(64'h0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'hA, 3'd1));
    respond(3, {64'h1122334455667788, 8'hF3, 8'h30}, 1'b0);
    check_fetch("irmov");
    F_stall_i = 1'b1;
    M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h50;
    step();
    M_icode_i = 4'h0; M_valA_i = 64'h0;
    F_stall_i = 1'b0;
    chk("redir_stall.valid", {63'h0, f_valid_o}, 64'h0);
    chk("redir_stall.pred",  F_predPC_o, 64'h0);
    wait_req(64'h50, "req_redir");

    // imem error forces ADR on an otherwise legal nop
    exp_q.push_back(mk(64'h50, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 3'd3));
    respond(1, {72'h0, 8'h10}, 1'b1);
    check_fetch("err");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
